// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------------------------
// reg_file_param
//
// Parametrised register file: DEPTH signed registers of WIDTH bits with one write port, two
// combinational read ports and a sequential clear engine that scrubs one entry per cycle.
//
// Parameters
//   WIDTH     data width of each register (signed)
//   DEPTH     number of registers, 2..2**ADDR_W
//   ADDR_W    address width
//   ZERO_REG  1: register 0 always reads 0 and ignores writes
//
// Optional feature
//   WRITE_BYPASS_EN  when defined, a read port addressing the entry being written (w_ack=1)
//                    returns w_data in the same cycle. Undefined: reads return the stored value.
//
// Ports
//   clk       in   clock, all state updates on posedge
//   rst       in   asynchronous active-high reset
//   w_flag    in   write request
//   w_addr    in   write address
//   w_data    in   write data (signed)
//   w_ack     out  write accepted this cycle (combinational)
//   r_addr_a  in   read address, port A
//   r_data_a  out  read data, port A (combinational)
//   r_addr_b  in   read address, port B
//   r_data_b  out  read data, port B (combinational)
//   clr_req   in   start clear sequence (sampled at posedge)
//   busy      out  clear sequence in progress
// ---------------------------------------------------------------------------------------------
module reg_file_param #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     w_flag,
  input  logic [ADDR_W-1:0]        w_addr,
  input  logic signed [WIDTH-1:0]  w_data,
  output logic                     w_ack,
  input  logic [ADDR_W-1:0]        r_addr_a,
  output logic signed [WIDTH-1:0]  r_data_a,
  input  logic [ADDR_W-1:0]        r_addr_b,
  output logic signed [WIDTH-1:0]  r_data_b,
  input  logic                     clr_req,
  output logic                     busy
);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  localparam logic [ADDR_W-1:0] CntLast = ADDR_W'(DEPTH - 1);

  logic signed [WIDTH-1:0] r_mem [DEPTH];

  state_e            r_state;
  state_e            w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_next;

  logic w_wr_in_range;
  logic w_wr_zero;
  logic w_ra_ok;
  logic w_rb_ok;

  // ---------------------------------------------------------------------------
  // Address qualification
  // ---------------------------------------------------------------------------
  // Register 0 is only special when the zero-register option is enabled.
  always_comb begin
    w_wr_in_range = 32'(w_addr) < DEPTH;
    w_wr_zero     = (ZERO_REG != 0) && (w_addr == '0);
    w_ra_ok       = (32'(r_addr_a) < DEPTH) && !((ZERO_REG != 0) && (r_addr_a == '0));
    w_rb_ok       = (32'(r_addr_b) < DEPTH) && !((ZERO_REG != 0) && (r_addr_b == '0));
  end

  // Reset gates the acknowledge directly so it drops the moment rst rises.
  always_comb begin
    w_ack = w_flag && !busy && !rst && w_wr_in_range && !w_wr_zero;
  end

  // ---------------------------------------------------------------------------
  // Clear FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Clear FSM: next-state logic
  // ---------------------------------------------------------------------------
  // A clr_req arriving while already clearing is dropped, not queued.
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    unique case (r_state)
      StIdle: begin
        if (clr_req) begin
          w_state_next   = StClear;
          w_clr_cnt_next = '0;
        end
      end
      StClear: begin
        if (r_clr_cnt == CntLast) begin
          w_state_next   = StIdle;
          w_clr_cnt_next = '0;
        end else begin
          w_clr_cnt_next = r_clr_cnt + 1'b1;
        end
      end
      default: begin
        w_state_next   = StIdle;
        w_clr_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Clear FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (r_state == StClear);
  end

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  // While clearing, w_ack is forced low, so scrub and write never collide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == StClear) begin
      r_mem[r_clr_cnt] <= '0;
    end else if (w_ack) begin
      r_mem[w_addr] <= w_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Out-of-range and zero-register addresses read as 0. Reads during a clear
  // see the partially scrubbed contents.
  always_comb begin
    r_data_a = '0;
    if (w_ra_ok) begin
      r_data_a = r_mem[r_addr_a];
    end
`ifdef WRITE_BYPASS_EN
    // w_ack already excludes the zero register and out-of-range addresses.
    if (w_ack && (w_addr == r_addr_a)) begin
      r_data_a = w_data;
    end
`endif
  end

  always_comb begin
    r_data_b = '0;
    if (w_rb_ok) begin
      r_data_b = r_mem[r_addr_b];
    end
`ifdef WRITE_BYPASS_EN
    if (w_ack && (w_addr == r_addr_b)) begin
      r_data_b = w_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

  logic clk = 1'b0;
  logic rst;

  // Main DUT: default parameters
  logic               w_flag, clr_req, w_ack, busy;
  logic [3:0]         w_addr, r_addr_a, r_addr_b;
  logic signed [15:0] w_data, r_data_a, r_data_b;

  // Second DUT: DEPTH=12, zero register enabled
  logic               z_w_flag, z_clr_req, z_w_ack, z_busy;
  logic [3:0]         z_w_addr, z_r_addr_a, z_r_addr_b;
  logic signed [15:0] z_w_data, z_r_data_a, z_r_data_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reg_file_param #(
    .WIDTH(16), .DEPTH(16), .ADDR_W(4), .ZERO_REG(0)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .w_flag   (w_flag),
    .w_addr   (w_addr),
    .w_data   (w_data),
    .w_ack    (w_ack),
    .r_addr_a (r_addr_a),
    .r_data_a (r_data_a),
    .r_addr_b (r_addr_b),
    .r_data_b (r_data_b),
    .clr_req  (clr_req),
    .busy     (busy)
  );

  reg_file_param #(
    .WIDTH(16), .DEPTH(12), .ADDR_W(4), .ZERO_REG(1)
  ) u_dz (
    .clk      (clk),
    .rst      (rst),
    .w_flag   (z_w_flag),
    .w_addr   (z_w_addr),
    .w_data   (z_w_data),
    .w_ack    (z_w_ack),
    .r_addr_a (z_r_addr_a),
    .r_data_a (z_r_data_a),
    .r_addr_b (z_r_addr_b),
    .r_data_b (z_r_data_b),
    .clr_req  (z_clr_req),
    .busy     (z_busy)
  );

  typedef struct {
    logic        wf;
    logic [3:0]  wa;
    logic [15:0] wd;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic        exp_ack;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    w_flag = 1'b1;
    w_addr = a;
    w_data = d;
    tick();
    w_flag = 1'b0;
  endtask

  initial begin
    int cnt;
    logic [15:0] exp_byp;

    rst = 1'b1;
    w_flag = 1'b1; w_addr = 4'd1; w_data = 16'h1111; clr_req = 1'b0;
    r_addr_a = 4'd0; r_addr_b = 4'd15;
    z_w_flag = 1'b0; z_w_addr = '0; z_w_data = '0; z_clr_req = 1'b0;
    z_r_addr_a = '0; z_r_addr_b = '0;

    // Vectors: writes never target a same-cycle read address, so build mode is irrelevant.
    vecs[0] = '{1'b1, 4'd3,  16'h7FFF, 4'd0,  4'd15, 1'b1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 4'd15, 16'h8000, 4'd3,  4'd0,  1'b1, 16'h7FFF, 16'h0000};
    vecs[2] = '{1'b0, 4'd3,  16'h0000, 4'd3,  4'd15, 1'b0, 16'h7FFF, 16'h8000};
    vecs[3] = '{1'b0, 4'd0,  16'h0000, 4'd15, 4'd15, 1'b0, 16'h8000, 16'h8000};
    vecs[4] = '{1'b1, 4'd0,  16'hA5A5, 4'd3,  4'd15, 1'b1, 16'h7FFF, 16'h8000};
    vecs[5] = '{1'b1, 4'd7,  16'h0001, 4'd0,  4'd1,  1'b1, 16'hA5A5, 16'h0000};
    vecs[6] = '{1'b0, 4'd7,  16'h0000, 4'd7,  4'd0,  1'b0, 16'h0001, 16'hA5A5};
    vecs[7] = '{1'b1, 4'd3,  16'hFFFF, 4'd15, 4'd7,  1'b1, 16'h8000, 16'h0001};
    vecs[8] = '{1'b0, 4'd0,  16'h0000, 4'd3,  4'd3,  1'b0, 16'hFFFF, 16'hFFFF};

    // Reset state, with a write request pending
    #3;
    chk("rst_ack", w_ack, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rd_a", r_data_a, 16'h0000);
    chk("rst_rd_b", r_data_b, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    w_flag = 1'b0;
    tick();

    // Table-driven write/read vectors
    for (int i = 0; i < 9; i++) begin
      w_flag = vecs[i].wf; w_addr = vecs[i].wa; w_data = vecs[i].wd;
      r_addr_a = vecs[i].ra; r_addr_b = vecs[i].rb;
      #1;
      chk($sformatf("vec%0d_ack", i), w_ack, vecs[i].exp_ack);
      chk($sformatf("vec%0d_a", i), r_data_a, vecs[i].exp_a);
      chk($sformatf("vec%0d_b", i), r_data_b, vecs[i].exp_b);
      tick();
    end
    w_flag = 1'b0;

    // Asynchronous reset mid-cycle: effects visible immediately
    w_flag = 1'b1; w_addr = 4'd4; w_data = 16'h4444;
    r_addr_a = 4'd3; r_addr_b = 4'd15;
    #1;
    chk("pre_rst_ack", w_ack, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_ack", w_ack, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_a", r_data_a, 16'h0000);
    chk("async_rst_b", r_data_b, 16'h0000);
    w_flag = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Read during write to the same address
`ifdef WRITE_BYPASS_EN
    exp_byp = 16'h1234;
`else
    exp_byp = 16'h0000;
`endif
    w_flag = 1'b1; w_addr = 4'd5; w_data = 16'h1234; r_addr_a = 4'd5; r_addr_b = 4'd5;
    #1;
    chk("rdw_same_cycle_a", r_data_a, exp_byp);
    chk("rdw_same_cycle_b", r_data_b, exp_byp);
    tick();
    w_flag = 1'b0;
    #1;
    chk("rdw_next_cycle", r_data_a, 16'h1234);

    // Fill everything, then clear
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h0100 + 16'(i));
    r_addr_a = 4'd9; #1;
    chk("fill_rd9", r_data_a, 16'h0109);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 1) begin
        w_flag = 1'b1; w_addr = 4'd2; w_data = 16'h9999;
        #1;
        chk("clr_wr_ack", w_ack, 1'b0);
      end
      if (cnt == 2) w_flag = 1'b0;
      if (cnt == 3) begin
        // Two scrub edges have passed: entries 0,1 are zero, 5 untouched
        r_addr_a = 4'd1; r_addr_b = 4'd5;
        #1;
        chk("clr_partial_1", r_data_a, 16'h0000);
        chk("clr_partial_5", r_data_b, 16'h0105);
      end
      if (cnt == 5) clr_req = 1'b1;
      if (cnt == 6) clr_req = 1'b0;
      tick();
    end
    chk("clr_busy_cycles", 16'(cnt), 16'd16);
    tick();
    chk("clr_req_not_queued", busy, 1'b0);
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      r_addr_a = 4'(i); #1;
      if (r_data_a !== 16'h0000) cnt++;
    end
    chk("clr_all_zero_count", 16'(cnt), 16'd0);

    // Reset during CLEAR at clr_cnt=7
    for (int i = 0; i < 16; i++) wr(4'(i), 16'h0200 + 16'(i));
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    r_addr_a = 4'd10; r_addr_b = 4'd12;
    #1;
    chk("pre_abort_rd10", r_data_a, 16'h020A);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_rd10", r_data_a, 16'h0000);
    chk("abort_rd12", r_data_b, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    tick();
    wr(4'd0, 16'h0A0A);
    wr(4'd9, 16'h0909);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("restart_busy", busy, 1'b1);
    tick();
    r_addr_a = 4'd0; r_addr_b = 4'd9;
    #1;
    chk("restart_entry0", r_data_a, 16'h0000);
    chk("restart_entry9", r_data_b, 16'h0909);
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      tick();
    end
    chk("restart_done", busy, 1'b0);
    chk("restart_rd9", r_data_b, 16'h0000);

    // Zero register and out-of-range on the DEPTH=12 instance
    z_w_flag = 1'b1; z_w_addr = 4'd0; z_w_data = 16'hBEEF; z_r_addr_a = 4'd0;
    #1;
    chk("zr_wr0_ack", z_w_ack, 1'b0);
    tick();
    chk("zr_rd0", z_r_data_a, 16'h0000);
    z_w_addr = 4'd13; z_w_data = 16'h1313; z_r_addr_b = 4'd13;
    #1;
    chk("oor_wr13_ack", z_w_ack, 1'b0);
    tick();
    chk("oor_rd13", z_r_data_b, 16'h0000);
    z_w_addr = 4'd11; z_w_data = 16'h0B0B;
    #1;
    chk("last_wr11_ack", z_w_ack, 1'b1);
    tick();
    z_w_flag = 1'b0;
    z_r_addr_a = 4'd11;
    #1;
    chk("last_rd11", z_r_data_a, 16'h0B0B);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
